// File: rtl/sap3_serial_tap.sv
// sap3_serial_tap: multi-channel framed serial debug tap with per-channel capture and round-robin pick.
// Define SAP3_SERIAL_TAP_PARITY_EN to append an even-parity bit after the data field.
module sap3_serial_tap #(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DIV    = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH*WIDTH-1:0] ch_data,
  input  logic [NUM_CH-1:0]       ch_valid,
  input  logic                    clear_ovf,
  output logic                    serial_out,
  output logic                    frame_start,
  output logic                    busy,
  output logic [NUM_CH-1:0]       ovf
);

  localparam int unsigned IDW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned IXW = IDW + 1;
  localparam int unsigned SRW = IDW + WIDTH;
  localparam int unsigned DVW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned BCW = $clog2(SRW + 1);
`ifdef SAP3_SERIAL_TAP_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_ID, S_DATA, S_PARITY, S_GAP
  } state_t;

  state_t             state, state_nx;
  logic [DVW-1:0]     div_cnt, div_nx;
  logic [BCW-1:0]     bit_cnt, bit_nx, bit_last;
  logic [SRW-1:0]     sr, sr_nx;
  logic               par, par_nx;
  logic [IDW-1:0]     ptr, ptr_nx;
  logic [NUM_CH-1:0]  pend, load;
  logic [WIDTH-1:0]   hold [NUM_CH];
  logic               grant_vld;
  logic [IDW-1:0]     grant_id;
  logic [IXW-1:0]     idx;
  logic               period_end;
  logic               so_nx, fs_nx, busy_nx;

  // Capture buffers: newest data always wins.
  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (ch_valid[c]) hold[c] <= ch_data[c*WIDTH +: WIDTH];
    end
  end

  // Pending and sticky overflow; a same-cycle load consumes the old word without flagging.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend <= '0;
      ovf  <= '0;
    end else begin
      pend <= ch_valid | (pend & ~load);
      ovf  <= (ch_valid & pend & ~load) | (clear_ovf ? '0 : ovf);
    end
  end

  // Round-robin search starting just after the last served channel.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = '0;
    idx       = '0;
    for (int i = 1; i <= NUM_CH; i++) begin
      idx = IXW'(ptr) + IXW'(i);
      if (idx >= IXW'(NUM_CH)) idx = idx - IXW'(NUM_CH);
      if (!grant_vld && pend[idx[IDW-1:0]]) begin
        grant_vld = 1'b1;
        grant_id  = idx[IDW-1:0];
      end
    end
  end

  always_comb begin
    case (state)
      S_ID:    bit_last = BCW'(IDW - 1);
      S_DATA:  bit_last = BCW'(WIDTH - 1);
      default: bit_last = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      div_cnt     <= '0;
      bit_cnt     <= '0;
      sr          <= '0;
      par         <= 1'b0;
      ptr         <= IDW'(NUM_CH - 1);
      serial_out  <= 1'b0;
      frame_start <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_nx;
      div_cnt     <= div_nx;
      bit_cnt     <= bit_nx;
      sr          <= sr_nx;
      par         <= par_nx;
      ptr         <= ptr_nx;
      serial_out  <= so_nx;
      frame_start <= fs_nx;
      busy        <= busy_nx;
    end
  end

  // Next state, shifter and the registered pin values for the upcoming cycle.
  always_comb begin
    state_nx   = state;
    div_nx     = div_cnt;
    bit_nx     = bit_cnt;
    sr_nx      = sr;
    par_nx     = par;
    ptr_nx     = ptr;
    load       = '0;
    period_end = (div_cnt == DVW'(DIV - 1));

    if (state == S_IDLE) begin
      if (grant_vld) begin
        state_nx       = S_START;
        sr_nx          = {grant_id, hold[grant_id]};
        par_nx         = ^{grant_id, hold[grant_id]};
        ptr_nx         = grant_id;
        load[grant_id] = 1'b1;
        div_nx         = '0;
        bit_nx         = '0;
      end
    end else begin
      div_nx = period_end ? '0 : div_cnt + DVW'(1);
      if (period_end) begin
        if (state == S_ID || state == S_DATA) sr_nx = sr << 1;
        if (bit_cnt == bit_last) begin
          bit_nx = '0;
          case (state)
            S_START:  state_nx = S_ID;
            S_ID:     state_nx = S_DATA;
            S_DATA:   state_nx = PAR_EN ? S_PARITY : S_GAP;
            S_PARITY: state_nx = S_GAP;
            default:  state_nx = S_IDLE;
          endcase
        end else begin
          bit_nx = bit_cnt + BCW'(1);
        end
      end
    end

    so_nx   = 1'b0;
    fs_nx   = 1'b0;
    busy_nx = (state_nx != S_IDLE);
    case (state_nx)
      S_START: begin
        so_nx = 1'b1;
        fs_nx = 1'b1;
      end
      S_ID, S_DATA: so_nx = sr_nx[SRW-1];
      S_PARITY:     so_nx = par_nx;
      default:      so_nx = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_sap3_serial_tap.sv
// Self-checking bench for sap3_serial_tap: frame-level reference model, table vectors and corner sequences.
module tb_sap3_serial_tap;

  localparam int unsigned NUM_CH = 2;
  localparam int unsigned WIDTH  = 8;
  localparam int unsigned DIV    = 2;
  localparam int unsigned IDW    = 1;
`ifdef SAP3_SERIAL_TAP_PARITY_EN
  localparam int unsigned PB = 1;
`else
  localparam int unsigned PB = 0;
`endif
  localparam int unsigned NBITS = 1 + IDW + WIDTH + PB + 1;
  localparam int unsigned FLEN  = NBITS * DIV;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic [NUM_CH*WIDTH-1:0] ch_data = '0;
  logic [NUM_CH-1:0]       ch_valid = '0;
  logic                    clear_ovf = 1'b0;
  logic                    serial_out, frame_start, busy;
  logic [NUM_CH-1:0]       ovf;

  sap3_serial_tap #(.NUM_CH(NUM_CH), .WIDTH(WIDTH), .DIV(DIV)) dut (
    .clk(clk), .rst_n(rst_n), .ch_data(ch_data), .ch_valid(ch_valid),
    .clear_ovf(clear_ovf), .serial_out(serial_out), .frame_start(frame_start),
    .busy(busy), .ovf(ovf)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference model: each granted frame is expanded into a list of per-clock pin values.
  typedef struct packed { logic so; logic fs; } cyc_t;
  cyc_t             m_q[$];
  logic [WIDTH-1:0] m_hold [NUM_CH];
  logic [NUM_CH-1:0] m_pend = '0;
  logic [NUM_CH-1:0] m_ovf = '0;
  int               m_ptr = NUM_CH - 1;
  bit               m_idle = 1'b1;
  logic             e_so = 1'b0, e_fs = 1'b0, e_bz = 1'b0;

  task automatic push_bit(input logic b, input logic fs);
    cyc_t x;
    x.so = b;
    x.fs = fs;
    for (int k = 0; k < DIV; k++) m_q.push_back(x);
  endtask

  task automatic model_step();
    int g;
    int c;
    logic p;
    logic [IDW-1:0] idv;
    cyc_t x;
    if (!rst_n) begin
      m_pend = '0; m_ovf = '0; m_ptr = NUM_CH - 1; m_idle = 1'b1;
      m_q.delete();
      e_so = 1'b0; e_fs = 1'b0; e_bz = 1'b0;
      return;
    end
    g = -1;
    if (m_idle) begin
      for (int i = 1; i <= NUM_CH; i++) begin
        c = (m_ptr + i) % NUM_CH;
        if (g < 0 && m_pend[c]) g = c;
      end
    end
    if (g >= 0) begin
      idv = IDW'(g);
      p = 1'b0;
      push_bit(1'b1, 1'b1);
      for (int b = IDW - 1; b >= 0; b--) begin push_bit(idv[b], 1'b0); p ^= idv[b]; end
      for (int b = WIDTH - 1; b >= 0; b--) begin push_bit(m_hold[g][b], 1'b0); p ^= m_hold[g][b]; end
      if (PB == 1) push_bit(p, 1'b0);
      push_bit(1'b0, 1'b0);
      m_pend[g] = 1'b0;
      m_ptr = g;
      m_idle = 1'b0;
    end
    if (m_q.size() > 0) begin
      x = m_q.pop_front();
      e_so = x.so; e_fs = x.fs; e_bz = 1'b1;
    end else begin
      e_so = 1'b0; e_fs = 1'b0; e_bz = 1'b0;
      m_idle = 1'b1;
    end
    if (clear_ovf) m_ovf = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_valid[i]) begin
        if (m_pend[i]) m_ovf[i] = 1'b1;
        m_hold[i] = ch_data[i*WIDTH +: WIDTH];
        m_pend[i] = 1'b1;
      end
    end
  endtask

  // Frame decoder on the pins, independent of the model.
  typedef struct { int id; logic [WIDTH-1:0] data; logic par; } frame_t;
  frame_t           fr_q[$];
  int               dec_cnt = -1;
  logic [NBITS-1:0] dv;

  task automatic decode(input logic was_rst);
    frame_t f;
    if (was_rst) begin dec_cnt = -1; return; end
    if (dec_cnt < 0 && frame_start) begin dec_cnt = 0; dv = '0; end
    if (dec_cnt >= 0) begin
      if (dec_cnt % DIV == 0) dv[NBITS-1-dec_cnt/DIV] = serial_out;
      dec_cnt++;
      if (dec_cnt == int'((NBITS - 1) * DIV)) begin
        f.id   = int'(dv[NBITS-2]);
        f.data = dv[NBITS-3 -: WIDTH];
        f.par  = dv[1];
        fr_q.push_back(f);
        dec_cnt = -1;
      end
    end
  endtask

  task automatic tick();
    logic was_rst;
    @(posedge clk);
    was_rst = !rst_n;
    model_step();
    #1;
    cyc++;
    check($sformatf("cycle%0d {so,fs,busy,ovf}", cyc),
          32'({serial_out, frame_start, busy, ovf}), 32'({e_so, e_fs, e_bz, m_ovf}));
    decode(was_rst);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; ch_valid = '0; clear_ovf = 1'b0;
    tick();
    rst_n = 1'b1;
    fr_q.delete();
  endtask

  task automatic drain();
    int quiet;
    quiet = 0;
    for (int i = 0; i < 2000 && quiet < 4; i++) begin
      tick();
      quiet = busy ? 0 : quiet + 1;
    end
    check("drain_timeout", 32'(quiet >= 4), 32'd1);
  endtask

  typedef struct {
    logic [NUM_CH-1:0] v;
    logic [NUM_CH*WIDTH-1:0] d;
    logic so, fs, bz;
    logic [NUM_CH-1:0] ov;
  } tv_t;
  tv_t tbl[$];

  initial begin
    tv_t r;
    logic [NBITS-1:0] fb;
    int busy_cnt;
    int nf;

    // Single ch0 frame of 0xA5, cycle by cycle.
`ifdef SAP3_SERIAL_TAP_PARITY_EN
    fb = {1'b1, 1'b0, 8'hA5, 1'b0, 1'b0};
`else
    fb = {1'b1, 1'b0, 8'hA5, 1'b0};
`endif
    r.v = 2'b01; r.d = 16'h00A5; r.so = 0; r.fs = 0; r.bz = 0; r.ov = 2'b00;
    tbl.push_back(r);
    for (int j = 0; j < int'(FLEN); j++) begin
      r.v = 2'b00; r.d = 16'h0000;
      r.so = fb[NBITS-1-j/DIV]; r.fs = (j < int'(DIV)); r.bz = 1'b1; r.ov = 2'b00;
      tbl.push_back(r);
    end
    for (int j = 0; j < 3; j++) begin
      r.v = 2'b00; r.d = 16'h0000; r.so = 0; r.fs = 0; r.bz = 0; r.ov = 2'b00;
      tbl.push_back(r);
    end

    tick();
    do_reset();
    check("reset_outputs", 32'({serial_out, frame_start, busy, ovf}), 32'd0);

    foreach (tbl[i]) begin
      ch_valid = tbl[i].v;
      ch_data  = tbl[i].d;
      tick();
      check($sformatf("tbl%0d", i), 32'({serial_out, frame_start, busy, ovf}),
            32'({tbl[i].so, tbl[i].fs, tbl[i].bz, tbl[i].ov}));
    end
    ch_valid = '0;

    // Simultaneous requests: ch0 first, then ch1.
    do_reset();
    ch_valid = 2'b11; ch_data = 16'h3412;
    tick();
    ch_valid = '0;
    drain();
    check("simul_nframes", 32'(fr_q.size()), 32'd2);
    if (fr_q.size() == 2) begin
      check("simul_f0", 32'({fr_q[0].id, 24'(fr_q[0].data)}), 32'h0000_0012);
      check("simul_f1", 32'({fr_q[1].id, 24'(fr_q[1].data)}), 32'h0100_0034);
    end
    check("simul_ovf", 32'(ovf), 32'd0);

    // Overflow on ch1 while a ch0 frame is on the wire.
    do_reset();
    ch_valid = 2'b01; ch_data = 16'h0055;
    tick();
    ch_valid = '0;
    repeat (4) tick();
    ch_valid = 2'b10; ch_data = 16'h0100;
    tick();
    ch_valid = '0;
    tick();
    ch_valid = 2'b10; ch_data = 16'h0200;
    tick();
    ch_valid = '0;
    drain();
    check("ovf_nframes", 32'(fr_q.size()), 32'd2);
    if (fr_q.size() == 2) begin
      check("ovf_f0", 32'({fr_q[0].id, 24'(fr_q[0].data)}), 32'h0000_0055);
      check("ovf_f1", 32'({fr_q[1].id, 24'(fr_q[1].data)}), 32'h0100_0002);
    end
    check("ovf_sticky", 32'(ovf), 32'h2);
    clear_ovf = 1'b1;
    tick();
    clear_ovf = 1'b0;
    check("ovf_cleared", 32'(ovf), 32'h0);

    // Reset during the fourth data bit aborts the frame and drops pending work.
    do_reset();
    ch_valid = 2'b11; ch_data = 16'h3CA5;
    tick();
    ch_valid = '0;
    repeat (11) tick();
    check("midframe_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("rst_mid_pins", 32'({serial_out, frame_start, busy}), 32'd0);
    busy_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (busy) busy_cnt++;
    end
    check("rst_no_resume", 32'(busy_cnt), 32'd0);
    check("rst_no_frames", 32'(fr_q.size()), 32'd0);

`ifdef SAP3_SERIAL_TAP_PARITY_EN
    // Parity bit and frame length with the parity field present.
    do_reset();
    ch_valid = 2'b01; ch_data = 16'h00A7;
    tick();
    ch_valid = '0;
    busy_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (busy) busy_cnt++;
    end
    check("par_len", 32'(busy_cnt), 32'd24);
    check("par_nframes", 32'(fr_q.size()), 32'd1);
    if (fr_q.size() == 1) check("par_a7", 32'(fr_q[0].par), 32'd1);
`endif

    // Fairness with both channels requesting every clock.
    do_reset();
    ch_valid = 2'b11;
    for (int i = 0; i < 120; i++) begin
      ch_data = 16'($urandom);
      tick();
    end
    ch_valid = '0;
    drain();
    nf = fr_q.size();
    check("fair_nframes_ge4", 32'(nf >= 4), 32'd1);
    for (int i = 0; i < nf && i < 6; i++) check($sformatf("fair_id%0d", i), 32'(fr_q[i].id), 32'(i % 2));
    check("fair_ovf", 32'(ovf), 32'h3);

    // Random traffic against the reference model.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      ch_valid[0] = ($urandom_range(0, 15) == 0);
      ch_valid[1] = ($urandom_range(0, 15) == 0);
      ch_data     = 16'($urandom);
      clear_ovf   = ($urandom_range(0, 31) == 0);
      rst_n       = ($urandom_range(0, 499) != 0);
      tick();
    end
    ch_valid = '0; clear_ovf = 1'b0; rst_n = 1'b1;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
